// File: rtl/switch_scan_pkg.sv
// Shared definitions for the switch scan controller: register map, CTRL bits, FSM states.
package switch_scan_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_INIT   = 1;
    localparam int unsigned CTRL_BUSY   = 2;

    // Width of the debounce run-length counter (STABLE_CNT is at most 15).
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        SAMPLE = 2'd3
    } scan_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Per-sample debouncer: accepts a new value after STABLE_CNT identical consecutive samples
// and reports the accepted bit changes as a same-cycle pulse vector.
module switch_debounce
    import switch_scan_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             reinit,
    input  logic             sample,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] debounced,
    output logic             init,
    output logic [WIDTH-1:0] change_c
);

    localparam int unsigned     ACCEPT_AT = STABLE_CNT - 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_len;
    logic             accept;

    // A sample that starts a new candidate has a prior run of zero, so STABLE_CNT=1 accepts at once.
    always_comb begin
        run_len  = (value == cand) ? cnt : '0;
        accept   = sample && !init && (value != debounced) && (run_len >= CNT_W'(ACCEPT_AT));
        change_c = accept ? (value ^ debounced) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced <= '0;
            cand      <= '0;
            cnt       <= '0;
            init      <= 1'b1;
        end else if (reinit) begin
            init <= 1'b1;
            cnt  <= '0;
        end else if (sample) begin
            if (init) begin
                debounced <= value;
                cand      <= value;
                cnt       <= '0;
                init      <= 1'b0;
            end else if (value == debounced) begin
                cnt <= '0;
            end else if (accept) begin
                debounced <= value;
                cand      <= value;
                cnt       <= '0;
            end else if (value != cand) begin
                cand <= value;
                cnt  <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_scan_controller.sv
// Polls the switches PIO on a prescaled tick, debounces the sample and exposes
// debounced state, edge capture, irq mask and control through an Avalon-MM slave.
module switch_scan_controller
    import switch_scan_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned POLL_DIV     = 50000,
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  pio_address,
    input  logic [31:0] pio_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int unsigned PRE_W = $clog2(POLL_DIV);
    localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    scan_state_e      state;
    scan_state_e      next_state;
    logic [PRE_W-1:0] presc;
    logic [LAT_W-1:0] wait_cnt;
    logic             tick;
    logic             enable;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] change;
    logic             init;
    logic             busy;
    logic             ctrl_wr;
    logic             edge_wr;
    logic             mask_wr;
    logic             disable_wr;
    logic             abort;
    logic             sample;
    logic [31:0]      read_mux;
    logic             unused_bits;

    assign ctrl_wr    = s_write && (s_address == ADDR_CTRL);
    assign edge_wr    = s_write && (s_address == ADDR_EDGE);
    assign mask_wr    = s_write && (s_address == ADDR_MASK);
    assign disable_wr = ctrl_wr && !s_writedata[CTRL_ENABLE];
    // A disabling write takes effect on the same edge, so a poll in flight never samples.
    assign abort      = !enable || disable_wr;
    assign tick       = enable && (presc == PRE_W'(POLL_DIV - 1));
    assign sample     = (state == SAMPLE) && !abort;
    assign busy       = (state != IDLE);
    assign irq        = |(edge_cap & irq_mask);
    assign unused_bits = ^{pio_readdata[31:WIDTH], s_writedata[31:WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (!enable || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (tick) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_cnt == LAT_W'(READ_LATENCY - 1)) next_state = SAMPLE;
            SAMPLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
        end
    end

    switch_debounce #(
        .WIDTH      (WIDTH),
        .STABLE_CNT (STABLE_CNT)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .reinit    (disable_wr),
        .sample    (sample),
        .value     (pio_readdata[WIDTH-1:0]),
        .debounced (debounced),
        .init      (init),
        .change_c  (change)
    );

    always_comb begin
        read_mux = '0;
        case (s_address)
            ADDR_DATA: read_mux = 32'(debounced);
            ADDR_EDGE: read_mux = 32'(edge_cap);
            ADDR_MASK: read_mux = 32'(irq_mask);
            default: begin
                read_mux[CTRL_ENABLE] = enable;
                read_mux[CTRL_INIT]   = init;
                read_mux[CTRL_BUSY]   = busy;
            end
        endcase
    end

    // New edges are OR-ed in after the W1C so a same-cycle capture survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable      <= 1'b1;
            irq_mask    <= '0;
            edge_cap    <= '0;
            s_readdata  <= '0;
            pio_address <= 2'd0;
        end else begin
            if (s_read) s_readdata <= read_mux;
            if (mask_wr) irq_mask <= s_writedata[WIDTH-1:0];
            if (ctrl_wr) enable <= s_writedata[CTRL_ENABLE];
            edge_cap    <= (edge_cap & ~(edge_wr ? s_writedata[WIDTH-1:0] : '0)) | change;
            pio_address <= 2'd0;
        end
    end

endmodule

// File: tb/tb_switch_scan_controller.sv
// Bench for switch_scan_controller: register table, directed poll/debounce sequences and
// randomized traffic checked against a schedule-and-history reference model.
module tb_switch_scan_controller;

    localparam int unsigned WIDTH        = 4;
    localparam int unsigned POLL_DIV     = 8;
    localparam int unsigned STABLE_CNT   = 3;
    localparam int unsigned READ_LATENCY = 1;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pio_address;
    logic [31:0] pio_readdata = '0;
    logic [1:0]  s_address = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    switch_scan_controller #(
        .WIDTH        (WIDTH),
        .POLL_DIV     (POLL_DIV),
        .STABLE_CNT   (STABLE_CNT),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pio_address  (pio_address),
        .pio_readdata (pio_readdata),
        .s_address    (s_address),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .irq          (irq)
    );

    // Reference model: polls are scheduled as (tick edge + 2 + READ_LATENCY) and the
    // debouncer keeps the recent sample history instead of a counter.
    int          m_cyc = 0;
    int          m_pre = 0;
    int          m_done = 0;
    int          m_samples = 0;
    bit          m_active = 0;
    bit          m_en = 1;
    bit          m_init = 1;
    logic [3:0]  m_deb = '0;
    logic [3:0]  m_edge = '0;
    logic [3:0]  m_mask = '0;
    logic [31:0] m_rdata = '0;
    logic [3:0]  m_hist[$];

    logic [31:0] t_rd;
    bit          t_dis, t_abort, t_tick, t_smp, t_run;
    logic [3:0]  t_v, t_chg;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            A_DATA:  return {28'd0, m_deb};
            A_EDGE:  return {28'd0, m_edge};
            A_MASK:  return {28'd0, m_mask};
            default: return {29'd0, m_active, m_init, m_en};
        endcase
    endfunction

    function automatic logic model_irq();
        return |(m_edge & m_mask);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pre    = 0;
            m_active = 0;
            m_en     = 1;
            m_init   = 1;
            m_deb    = '0;
            m_edge   = '0;
            m_mask   = '0;
            m_rdata  = '0;
            m_hist.delete();
        end else begin
            m_cyc   = m_cyc + 1;
            t_rd    = model_read(s_address);
            t_dis   = s_write && (s_address == A_CTRL) && !s_writedata[0];
            t_abort = !m_en || t_dis;
            t_tick  = m_en && (m_pre == POLL_DIV - 1);
            t_smp   = m_active && (m_done == m_cyc) && !t_abort;
            t_chg   = '0;
            if (t_smp) begin
                t_v = pio_readdata[3:0];
                m_samples++;
                if (m_init) begin
                    m_deb  = t_v;
                    m_init = 0;
                    m_hist.delete();
                end else begin
                    m_hist.push_back(t_v);
                    if (m_hist.size() > STABLE_CNT) void'(m_hist.pop_front());
                    t_run = (m_hist.size() == STABLE_CNT);
                    foreach (m_hist[i]) if (m_hist[i] != t_v) t_run = 0;
                    if (t_run && (t_v != m_deb)) begin
                        t_chg = t_v ^ m_deb;
                        m_deb = t_v;
                        m_hist.delete();
                    end
                end
            end
            if (t_abort) m_active = 0;
            else if (m_active && (m_done == m_cyc)) m_active = 0;
            else if (!m_active && t_tick) begin
                m_active = 1;
                m_done   = m_cyc + 2 + READ_LATENCY;
            end
            m_pre = m_en ? ((m_pre == POLL_DIV - 1) ? 0 : m_pre + 1) : 0;
            if (s_read) m_rdata = t_rd;
            if (s_write) begin
                case (s_address)
                    A_EDGE: m_edge = m_edge & ~s_writedata[3:0];
                    A_MASK: m_mask = s_writedata[3:0];
                    A_CTRL: begin
                        m_en = s_writedata[0];
                        if (!s_writedata[0]) begin
                            m_init = 1;
                            m_hist.delete();
                        end
                    end
                    default: ;
                endcase
            end
            m_edge = m_edge | t_chg;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_cycle(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd);
        s_read      = rd;
        s_write     = wr;
        s_address   = a;
        s_writedata = wd;
        @(posedge clk);
        #1;
        s_read  = 1'b0;
        s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_cycle(1'b1, 1'b0, a, 32'd0);
        d = s_readdata;
    endtask

    logic [3:0] sw = '0;

    task automatic set_sw(input logic [3:0] v);
        sw = v;
        pio_readdata = {28'($urandom()), v};
    endtask

    task automatic wait_samples(input int k);
        int target;
        int guard;
        target = m_samples + k;
        guard  = 0;
        while ((m_samples < target) && (guard < 4 * POLL_DIV * k + 8)) begin
            idle(1);
            guard++;
        end
        if (m_samples < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_samples: timed out at %0d samples, needed %0d", m_samples, target);
        end
    endtask

    // Returns when the next edge is d edges before the poll's sample edge (d=1: SAMPLE, d=2: WAIT).
    task automatic wait_phase(input int d);
        int guard;
        guard = 0;
        while (!(m_active && (m_done == m_cyc + d)) && (guard < 4 * POLL_DIV)) begin
            idle(1);
            guard++;
        end
        if (!(m_active && (m_done == m_cyc + d))) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_phase: timed out waiting for phase %0d", d);
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    localparam int NVEC = 15;
    vec_t        vecs[NVEC];
    logic [31:0] d;
    int          r;
    logic        rd, wr;
    logic [1:0]  a;
    logic [31:0] wd;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{"ctrl_rd_reset", 1'b1, 1'b0, A_CTRL, 32'h0,         32'h3, 1'b0};
        vecs[1]  = '{"ctrl_disable",  1'b0, 1'b1, A_CTRL, 32'h0,         32'h3, 1'b0};
        vecs[2]  = '{"ctrl_rd_off",   1'b1, 1'b0, A_CTRL, 32'h0,         32'h2, 1'b0};
        vecs[3]  = '{"mask_wr_rd",    1'b1, 1'b1, A_MASK, 32'hFFFF_FFFA, 32'h0, 1'b0};
        vecs[4]  = '{"mask_rd",       1'b1, 1'b0, A_MASK, 32'h0,         32'hA, 1'b0};
        vecs[5]  = '{"data_wr_ro",    1'b1, 1'b1, A_DATA, 32'hF,         32'h0, 1'b0};
        vecs[6]  = '{"data_rd",       1'b1, 1'b0, A_DATA, 32'h0,         32'h0, 1'b0};
        vecs[7]  = '{"edge_w1c_rd",   1'b1, 1'b1, A_EDGE, 32'hF,         32'h0, 1'b0};
        vecs[8]  = '{"mask_rd2",      1'b1, 1'b0, A_MASK, 32'h0,         32'hA, 1'b0};
        vecs[9]  = '{"rdata_hold",    1'b0, 1'b0, A_DATA, 32'h0,         32'hA, 1'b0};
        vecs[10] = '{"ctrl_ro_bits",  1'b1, 1'b1, A_CTRL, 32'h6,         32'h2, 1'b0};
        vecs[11] = '{"ctrl_rd",       1'b1, 1'b0, A_CTRL, 32'h0,         32'h2, 1'b0};
        vecs[12] = '{"mask_clr",      1'b1, 1'b1, A_MASK, 32'h0,         32'hA, 1'b0};
        vecs[13] = '{"mask_rd0",      1'b1, 1'b0, A_MASK, 32'h0,         32'h0, 1'b0};
        vecs[14] = '{"edge_rd",       1'b1, 1'b0, A_EDGE, 32'h0,         32'h0, 1'b0};

        // Reset state
        idle(3);
        check("reset_rdata", s_readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_pio_address", 32'(pio_address), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            bus_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check({vecs[i].name, "_rdata"}, s_readdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
        end

        // First poll initialises without edges
        set_sw(4'b0101);
        bus_cycle(1'b0, 1'b1, A_CTRL, 32'h1);
        wait_samples(1);
        bus_read(A_DATA, d); check("t1_data", d, 32'h5);
        bus_read(A_EDGE, d); check("t1_edge", d, 32'h0);
        check("t1_irq", 32'(irq), 32'h0);
        bus_read(A_CTRL, d); check("t1_ctrl_init", 32'(d[1]), 32'h0);

        // Change held for STABLE_CNT polls is accepted
        set_sw(4'b0111);
        wait_samples(2);
        bus_read(A_DATA, d); check("t2_data_pending", d, 32'h5);
        wait_samples(1);
        bus_read(A_DATA, d); check("t2_data", d, 32'h7);
        bus_read(A_EDGE, d); check("t2_edge", d, 32'h2);
        check("t2_irq_masked", 32'(irq), 32'h0);
        bus_cycle(1'b0, 1'b1, A_MASK, 32'h2);
        check("t2_irq", 32'(irq), 32'h1);

        // Short glitch is rejected
        set_sw(4'b0101);
        wait_samples(2);
        set_sw(4'b0111);
        wait_samples(2);
        bus_read(A_DATA, d); check("t3_data", d, 32'h7);
        bus_read(A_EDGE, d); check("t3_edge", d, 32'h2);

        // W1C on the same edge as a new capture of that bit: set wins
        set_sw(4'b0101);
        wait_samples(2);
        wait_phase(1);
        bus_cycle(1'b0, 1'b1, A_EDGE, 32'h2);
        check("t4_irq_kept", 32'(irq), 32'h1);
        bus_read(A_DATA, d); check("t4_data", d, 32'h5);
        bus_read(A_EDGE, d); check("t4_edge_kept", d, 32'h2);
        bus_cycle(1'b0, 1'b1, A_EDGE, 32'h2);
        check("t4_irq_clr", 32'(irq), 32'h0);
        bus_read(A_EDGE, d); check("t4_edge_clr", d, 32'h0);

        // Disable during WAIT aborts the poll; re-enable reinitialises
        set_sw(4'b0000);
        wait_phase(2);
        bus_cycle(1'b0, 1'b1, A_CTRL, 32'h0);
        bus_read(A_CTRL, d); check("t5_ctrl_abort", d, 32'h2);
        idle(3 * POLL_DIV);
        bus_read(A_CTRL, d); check("t5_ctrl_idle", d, 32'h2);
        bus_read(A_DATA, d); check("t5_data_held", d, 32'h5);
        set_sw(4'b1010);
        bus_cycle(1'b0, 1'b1, A_CTRL, 32'h1);
        wait_samples(1);
        bus_read(A_DATA, d); check("t5_data_reinit", d, 32'hA);
        bus_read(A_EDGE, d); check("t5_edge_none", d, 32'h0);
        bus_read(A_CTRL, d); check("t5_ctrl_bits", d & 32'h3, 32'h1);

        // Reset in the middle of a poll
        bus_cycle(1'b0, 1'b1, A_MASK, 32'hF);
        set_sw(4'b0101);
        wait_samples(3);
        bus_read(A_EDGE, d); check("t6_edge_all", d, 32'hF);
        check("t6_irq_pre", 32'(irq), 32'h1);
        wait_phase(2);
        reset_n = 1'b0;
        #1;
        check("t6_rdata_reset", s_readdata, 32'h0);
        check("t6_irq_reset", 32'(irq), 32'h0);
        check("t6_pio_address", 32'(pio_address), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_read(A_CTRL, d); check("t6_ctrl", d, 32'h3);
        bus_read(A_DATA, d); check("t6_data", d, 32'h0);
        bus_read(A_EDGE, d); check("t6_edge", d, 32'h0);
        bus_read(A_MASK, d); check("t6_mask", d, 32'h0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 23) == 0) begin
                if ($urandom_range(0, 1) == 0) set_sw(4'($urandom_range(0, 15)));
                else set_sw(sw ^ (4'b0001 << $urandom_range(0, 3)));
            end
            r  = $urandom_range(0, 99);
            rd = (r < 40);
            wr = 1'b0;
            a  = 2'($urandom_range(0, 3));
            wd = $urandom();
            if (r >= 40 && r < 46) begin
                wr = 1'b1;
                a  = A_EDGE;
            end else if (r >= 46 && r < 50) begin
                wr = 1'b1;
                a  = A_MASK;
            end else if (r == 50) begin
                wr = 1'b1;
                a  = A_CTRL;
                wd = wd & ~32'h1;
            end else if (r >= 51 && r < 55) begin
                wr = 1'b1;
                a  = A_CTRL;
                wd = wd | 32'h1;
            end
            if (wr && ($urandom_range(0, 3) == 0)) rd = 1'b1;
            bus_cycle(rd, wr, a, wd);
            check("rand_rdata", s_readdata, m_rdata);
            check("rand_irq", 32'(irq), 32'(model_irq()));
            if (c % 100 == 0) check("rand_pio_address", 32'(pio_address), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
